bomb_game_ctrl: RTL

BOMB_GAME_CTRL -- requirements
Module: bomb_game_ctrl

---
 rtl/bomb_game_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bomb_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bomb_game_ctrl
// Description : Game controller for a timed defuse puzzle. Collects four key
//               digits per attempt, checks them against a code, counts wrong
//               attempts and warning ticks, and holds the result (CLEAR or
//               FAIL) for a fixed number of seconds before returning to idle.
// Revision    : 1.0 - initial release
// ============================================================================
module bomb_game_ctrl #(
    parameter logic [15:0] P_CODE      = 16'h1234,
    parameter int          P_MAX_WRONG = 3,
    parameter int          P_HOLD_SEC  = 5
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_StartPulse,
    input  logic [3:0]  i_Key,
    input  logic        i_KeyValid,
    input  logic        i_Sec1Tick,
    input  logic        i_Sec10Tick,
    input  logic        i_Sec30Tick,
    output logic [2:0]  o_State,
    output logic [1:0]  o_Warn,
    output logic [1:0]  o_WrongCnt,
    output logic [2:0]  o_DigitCnt,
    output logic [15:0] o_Entry
);

    localparam int            c_HOLD_W    = (P_HOLD_SEC < 2) ? 1 : $clog2(P_HOLD_SEC + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = c_HOLD_W'(P_HOLD_SEC);
    localparam logic [1:0]    c_MAX_WRONG = 2'(P_MAX_WRONG);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_START = 3'b001,
        S_CLEAR = 3'b010,
        S_FAIL  = 3'b011
    } state_t;

    state_t              r_State;
    logic [1:0]          r_Warn;
    logic [1:0]          r_WrongCnt;
    logic [2:0]          r_DigitCnt;
    logic [15:0]         r_Entry;
    logic [c_HOLD_W-1:0] r_Hold;

    state_t              w_StateNext;
    logic [1:0]          w_WarnNext;
    logic [1:0]          w_WrongNext;
    logic [2:0]          w_DigitNext;
    logic [15:0]         w_EntryNext;
    logic [c_HOLD_W-1:0] w_HoldNext;

    logic [15:0]         w_NewEntry;
    logic [1:0]          w_WrongInc;
    logic [c_HOLD_W-1:0] w_HoldInc;

    assign w_NewEntry = {r_Entry[11:0], i_Key};
    assign w_WrongInc = r_WrongCnt + 2'd1;
    assign w_HoldInc  = r_Hold + c_HOLD_W'(1);

    // Next-state and next-datapath values; later assignments in START carry priority
    always_comb begin
        w_StateNext = r_State;
        w_WarnNext  = r_Warn;
        w_WrongNext = r_WrongCnt;
        w_DigitNext = r_DigitCnt;
        w_EntryNext = r_Entry;
        w_HoldNext  = r_Hold;
        case (r_State)
            S_IDLE: begin
                if (i_StartPulse) begin
                    w_StateNext = S_START;
                    w_WarnNext  = 2'd0;
                    w_WrongNext = 2'd0;
                    w_DigitNext = 3'd0;
                    w_EntryNext = 16'h0000;
                    w_HoldNext  = '0;
                end
            end
            S_START: begin
                if (i_Sec10Tick && (r_Warn != 2'd3)) begin
                    w_WarnNext = r_Warn + 2'd1;
                end
                if (i_KeyValid) begin
                    if (r_DigitCnt == 3'd3) begin
                        if (w_NewEntry == P_CODE) begin
                            w_EntryNext = w_NewEntry;
                            w_DigitNext = 3'd4;
                            w_StateNext = S_CLEAR;
                        end else begin
                            // Wrong attempt: restart entry, fail once the limit is hit
                            w_WrongNext = w_WrongInc;
                            w_DigitNext = 3'd0;
                            w_EntryNext = 16'h0000;
                            if (w_WrongInc == c_MAX_WRONG) begin
                                w_StateNext = S_FAIL;
                            end
                        end
                    end else begin
                        w_EntryNext = w_NewEntry;
                        w_DigitNext = r_DigitCnt + 3'd1;
                    end
                end
                // Timeout overrides any same-cycle code result
                if (i_Sec30Tick) begin
                    w_StateNext = S_FAIL;
                end
            end
            S_CLEAR, S_FAIL: begin
                if (i_Sec1Tick) begin
                    if (w_HoldInc == c_HOLD_MAX) begin
                        w_StateNext = S_IDLE;
                        w_HoldNext  = '0;
                    end else begin
                        w_HoldNext  = w_HoldInc;
                    end
                end
            end
            default: begin
                w_StateNext = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_State    <= S_IDLE;
            r_Warn     <= 2'd0;
            r_WrongCnt <= 2'd0;
            r_DigitCnt <= 3'd0;
            r_Entry    <= 16'h0000;
            r_Hold     <= '0;
        end else begin
            r_State    <= w_StateNext;
            r_Warn     <= w_WarnNext;
            r_WrongCnt <= w_WrongNext;
            r_DigitCnt <= w_DigitNext;
            r_Entry    <= w_EntryNext;
            r_Hold     <= w_HoldNext;
        end
    end

    assign o_State    = r_State;
    assign o_Warn     = r_Warn;
    assign o_WrongCnt = r_WrongCnt;
    assign o_DigitCnt = r_DigitCnt;
    assign o_Entry    = r_Entry;

endmodule
`default_nettype wire
